// File: rtl/gate_arbiter_if.sv
// gate_arbiter_if: requester/consumer bundle for the shared gate unit.
// master drives requests and resp_ready; slave is the arbiter side.
interface gate_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 1
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   gnt;
   logic              resp_valid;
   logic              resp_ready;
   logic [IDW-1:0]    resp_id;
   logic [W-1:0]      resp_o1;
   logic [W-1:0]      resp_o2;
   logic [W-1:0]      resp_o3;

   modport master (
      output req, req_a, req_b, resp_ready,
      input  gnt, resp_valid, resp_id,
      input  resp_o1, resp_o2, resp_o3
   );

   modport slave (
      input  req, req_a, req_b, resp_ready,
      output gnt, resp_valid, resp_id,
      output resp_o1, resp_o2, resp_o3
   );
endinterface

// File: rtl/gate_arbiter.sv
// gate_arbiter: round-robin sharing of one AND/OR/NOT unit among NREQ users.
// Define GATE_ARBITER_STATS_EN to add the saturating done_cnt output.
module gate_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 1,
   parameter int LAT  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef GATE_ARBITER_STATS_EN
   output logic [15:0] done_cnt,
`endif
   gate_arbiter_if.slave bus
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);
   localparam logic [CW-1:0]  CNT_LD = CW'(LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  ptr, ptr_nxt;
   logic [IDW-1:0]  id, id_nxt;
   logic [IDW-1:0]  rid, rid_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [W-1:0]    op_a, op_a_nxt;
   logic [W-1:0]    op_b, op_b_nxt;
   logic [W-1:0]    o1, o1_nxt;
   logic [W-1:0]    o2, o2_nxt;
   logic [W-1:0]    o3, o3_nxt;
   logic [NREQ-1:0] gnt, gnt_nxt;
   logic            rvalid, rvalid_nxt;
   logic            fire;

   logic            found_lo, found_hi;
   logic [IDW-1:0]  win_lo, win_hi, win;

   // Lowest requester at/above ptr wins; else wrap to lowest overall.
   always_comb begin
      found_lo = 1'b0;
      found_hi = 1'b0;
      win_lo   = '0;
      win_hi   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            found_lo = 1'b1;
            win_lo   = IDW'(i);
         end
         if (bus.req[i] && (IDW'(i) >= ptr)) begin
            found_hi = 1'b1;
            win_hi   = IDW'(i);
         end
      end
      win = found_hi ? win_hi : win_lo;
   end

   assign fire = rvalid & bus.resp_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= '0;
         id     <= '0;
         rid    <= '0;
         cnt    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         o1     <= '0;
         o2     <= '0;
         o3     <= '0;
         gnt    <= '0;
         rvalid <= 1'b0;
      end else begin
         state  <= state_nxt;
         ptr    <= ptr_nxt;
         id     <= id_nxt;
         rid    <= rid_nxt;
         cnt    <= cnt_nxt;
         op_a   <= op_a_nxt;
         op_b   <= op_b_nxt;
         o1     <= o1_nxt;
         o2     <= o2_nxt;
         o3     <= o3_nxt;
         gnt    <= gnt_nxt;
         rvalid <= rvalid_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      id_nxt     = id;
      rid_nxt    = rid;
      cnt_nxt    = cnt;
      op_a_nxt   = op_a;
      op_b_nxt   = op_b;
      o1_nxt     = o1;
      o2_nxt     = o2;
      o3_nxt     = o3;
      gnt_nxt    = '0;
      rvalid_nxt = rvalid;
      unique case (state)
         IDLE: begin
            if (found_lo) begin
               op_a_nxt     = bus.req_a[win*W +: W];
               op_b_nxt     = bus.req_b[win*W +: W];
               id_nxt       = win;
               ptr_nxt      = (win == LAST) ? '0 : win + 1'b1;
               cnt_nxt      = CNT_LD;
               gnt_nxt[win] = 1'b1;
               state_nxt    = BUSY;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               o1_nxt     = op_a & op_b;
               o2_nxt     = op_a | op_b;
               o3_nxt     = ~op_a;
               rid_nxt    = id;
               rvalid_nxt = 1'b1;
               state_nxt  = DONE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         DONE: begin
            if (fire) begin
               rvalid_nxt = 1'b0;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef GATE_ARBITER_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         done_cnt <= '0;
      else if (fire && (done_cnt != 16'hFFFF))
         done_cnt <= done_cnt + 16'd1;
   end
`endif

   assign bus.gnt        = gnt;
   assign bus.resp_valid = rvalid;
   assign bus.resp_id    = rid;
   assign bus.resp_o1    = o1;
   assign bus.resp_o2    = o2;
   assign bus.resp_o3    = o3;
endmodule

// File: tb/tb_gate_arbiter.sv
// tb_gate_arbiter: directed checks on three gate_arbiter configurations.
// dut_a W=1 LAT=2, dut_b W=1 LAT=1, dut_c W=4 LAT=4.
module tb_gate_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   gate_arbiter_if #(.NREQ(4), .W(1)) ia ();
   gate_arbiter_if #(.NREQ(4), .W(1)) ib ();
   gate_arbiter_if #(.NREQ(4), .W(4)) ic ();

`ifdef GATE_ARBITER_STATS_EN
   logic [15:0] dc_a, dc_b, dc_c;
`endif

   gate_arbiter #(.NREQ(4), .W(1), .LAT(2)) dut_a (
      .clk(clk), .rst_n(rst_n),
`ifdef GATE_ARBITER_STATS_EN
      .done_cnt(dc_a),
`endif
      .bus(ia)
   );

   gate_arbiter #(.NREQ(4), .W(1), .LAT(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
`ifdef GATE_ARBITER_STATS_EN
      .done_cnt(dc_b),
`endif
      .bus(ib)
   );

   gate_arbiter #(.NREQ(4), .W(4), .LAT(4)) dut_c (
      .clk(clk), .rst_n(rst_n),
`ifdef GATE_ARBITER_STATS_EN
      .done_cnt(dc_c),
`endif
      .bus(ic)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [9:0] obs;
      int n;
      rst_n = 1'b0;
      ia.req = 4'hF;
      ia.resp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         obs = {ia.gnt, ia.resp_valid, ia.resp_id,
                ia.resp_o1, ia.resp_o2, ia.resp_o3};
         checks++;
         if (obs !== 10'd0)
            $display("FAIL reset_hold c%0d got %h want 0", c, obs);
         else passes++;
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (ia.gnt !== 4'b0001)
         $display("FAIL reset_first_gnt got %b want 0001", ia.gnt);
      else passes++;
      ia.req = 4'h0;
      n = 0;
      while (ia.resp_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 10 || ia.resp_id !== 2'd0)
         $display("FAIL reset_drain n=%0d id=%0d want id 0", n, ia.resp_id);
      else passes++;
      tick();
      checks++;
      if (ia.resp_valid !== 1'b0)
         $display("FAIL reset_hs valid=%b want 0", ia.resp_valid);
      else passes++;
   endtask

   task automatic test_single();
      ia.resp_ready = 1'b1;
      ia.req_a = 4'b0100;
      ia.req_b = 4'b0000;
      ia.req = 4'b0100;
      tick();
      checks++;
      if (ia.gnt !== 4'b0100)
         $display("FAIL single_gnt got %b want 0100", ia.gnt);
      else passes++;
      ia.req = 4'b0000;
      ia.req_a = 4'hF;
      ia.req_b = 4'hF;
      tick();
      checks++;
      if (ia.gnt !== 4'b0000 || ia.resp_valid !== 1'b0)
         $display("FAIL single_c2 gnt=%b valid=%b want 0000/0",
                  ia.gnt, ia.resp_valid);
      else passes++;
      tick();
      checks++;
      if ({ia.resp_valid, ia.resp_id, ia.resp_o1, ia.resp_o2,
           ia.resp_o3} !== 6'b1_10_010)
         $display("FAIL single_resp got v%b id%0d o%b%b%b want v1 id2 o010",
                  ia.resp_valid, ia.resp_id,
                  ia.resp_o1, ia.resp_o2, ia.resp_o3);
      else passes++;
      tick();
      checks++;
      if (ia.resp_valid !== 1'b0)
         $display("FAIL single_hs valid=%b want 0", ia.resp_valid);
      else passes++;
   endtask

   task automatic test_backpressure();
      logic [10:0] obs;
      int n;
      ia.resp_ready = 1'b0;
      ia.req_a = 4'b1000;
      ia.req_b = 4'b1000;
      ia.req = 4'hF;
      tick();
      checks++;
      if (ia.gnt !== 4'b1000)
         $display("FAIL bp_gnt got %b want 1000", ia.gnt);
      else passes++;
      ia.req = 4'b0111;
      tick();
      tick();
      for (int c = 0; c < 10; c++) begin
         obs = {ia.resp_valid, ia.resp_id, ia.resp_o1,
                ia.resp_o2, ia.resp_o3, ia.gnt};
         checks++;
         if (obs !== 11'b1_11_110_0000)
            $display("FAIL bp_hold c%0d got %b want 11111100000", c, obs);
         else passes++;
         tick();
      end
      ia.resp_ready = 1'b1;
      tick();
      checks++;
      if (ia.resp_valid !== 1'b0)
         $display("FAIL bp_hs valid=%b want 0", ia.resp_valid);
      else passes++;
      tick();
      checks++;
      if (ia.gnt !== 4'b0001)
         $display("FAIL bp_next_gnt got %b want 0001", ia.gnt);
      else passes++;
      ia.req = 4'b0000;
      n = 0;
      while (ia.resp_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 10)
         $display("FAIL bp_drain timeout valid=%b want 1", ia.resp_valid);
      else passes++;
      tick();
   endtask

   task automatic test_round_robin();
      logic [3:0] g[6];
      int t[6];
      logic [3:0] eg[6];
      int k;
      eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      k = 0;
      ib.resp_ready = 1'b1;
      ib.req = 4'hF;
      for (int c = 1; c <= 40 && k < 6; c++) begin
         tick();
         if (ib.gnt !== 4'b0000) begin
            g[k] = ib.gnt;
            t[k] = c;
            k++;
         end
      end
      checks++;
      if (k != 6)
         $display("FAIL rr_count got %0d grants want 6", k);
      else passes++;
      for (int i = 0; i < k; i++) begin
         checks++;
         if (g[i] !== eg[i])
            $display("FAIL rr_order #%0d got %b want %b", i, g[i], eg[i]);
         else passes++;
         if (i > 0) begin
            checks++;
            if (t[i] - t[i-1] != 3)
               $display("FAIL rr_gap #%0d got %0d want 3", i, t[i] - t[i-1]);
            else passes++;
         end
      end
      ib.req = 4'h0;
      for (int c = 0; c < 6; c++) tick();
      checks++;
      if (ib.resp_valid !== 1'b0)
         $display("FAIL rr_drain valid=%b want 0", ib.resp_valid);
      else passes++;
   endtask

   task automatic test_mid_reset();
      logic seen;
      int n;
      ic.resp_ready = 1'b0;
      ic.req_a = 16'h0;
      ic.req_b = 16'h0;
      ic.req = 4'b0010;
      tick();
      checks++;
      if (ic.gnt !== 4'b0010)
         $display("FAIL mr_gnt got %b want 0010", ic.gnt);
      else passes++;
      ic.req = 4'b0000;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if ({ic.gnt, ic.resp_valid, ic.resp_id, ic.resp_o1,
           ic.resp_o2, ic.resp_o3} !== 19'd0)
         $display("FAIL mr_reset_vals gnt=%b v=%b id=%0d want 0",
                  ic.gnt, ic.resp_valid, ic.resp_id);
      else passes++;
`ifdef GATE_ARBITER_STATS_EN
      checks++;
      if ({dc_a, dc_b, dc_c} !== 48'd0)
         $display("FAIL mr_done_cnt got %h %h %h want 0", dc_a, dc_b, dc_c);
      else passes++;
`endif
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (ic.resp_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0)
         $display("FAIL mr_no_resp valid seen=%b want 0", seen);
      else passes++;
      ic.req = 4'b0011;
      tick();
      checks++;
      if (ic.gnt !== 4'b0001)
         $display("FAIL mr_next_gnt got %b want 0001", ic.gnt);
      else passes++;
      ic.req = 4'b0000;
      ic.resp_ready = 1'b1;
      n = 0;
      while (ic.resp_valid !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 12 || ic.resp_id !== 2'd0)
         $display("FAIL mr_drain n=%0d id=%0d want id 0", n, ic.resp_id);
      else passes++;
      tick();
   endtask

   task automatic test_width();
      int n;
`ifdef GATE_ARBITER_STATS_EN
      logic [15:0] before;
      before = dc_c;
`endif
      ic.resp_ready = 1'b0;
      ic.req_a = 16'h0030;
      ic.req_b = 16'h0050;
      ic.req = 4'b0010;
      tick();
      checks++;
      if (ic.gnt !== 4'b0010)
         $display("FAIL w4_gnt got %b want 0010", ic.gnt);
      else passes++;
      ic.req = 4'b0000;
      n = 0;
      while (ic.resp_valid !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      checks++;
      if (n != 4)
         $display("FAIL w4_latency got %0d cycles after gnt want 4", n);
      else passes++;
      checks++;
      if ({ic.resp_id, ic.resp_o1, ic.resp_o2, ic.resp_o3} !==
          {2'd1, 4'b0001, 4'b0111, 4'b1100})
         $display("FAIL w4_resp id=%0d o1=%b o2=%b o3=%b want 1 0001 0111 1100",
                  ic.resp_id, ic.resp_o1, ic.resp_o2, ic.resp_o3);
      else passes++;
      ic.resp_ready = 1'b1;
      tick();
      checks++;
      if (ic.resp_valid !== 1'b0)
         $display("FAIL w4_hs valid=%b want 0", ic.resp_valid);
      else passes++;
`ifdef GATE_ARBITER_STATS_EN
      checks++;
      if (dc_c !== before + 16'd1)
         $display("FAIL w4_done_cnt got %0d want %0d", dc_c, before + 16'd1);
      else passes++;
`endif
   endtask

   initial begin
      ia.req = '0; ia.req_a = '0; ia.req_b = '0; ia.resp_ready = 1'b0;
      ib.req = '0; ib.req_a = '0; ib.req_b = '0; ib.resp_ready = 1'b0;
      ic.req = '0; ic.req_a = '0; ic.req_b = '0; ic.resp_ready = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_round_robin();
      test_mid_reset();
      test_width();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
